tl_ul_arb2_sequencer: RTL

Two-requester TileLink-UL arbiter and sequencer sharing one downstream A/D port. That port is the fragmenter/width-widget adapter chain (32-bit data, 15-bit address, 7-bit source). The block does round-robin A-channel arbitration with burst locking and prepends a requester bit to source. It routes D responses back by that bit and limits outstanding requests per requester.

---
 rtl/tl_ul_arb2_sequencer.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/tl_ul_arb2_sequencer.sv
// Two-requester TileLink-UL A/D arbiter with burst lock, source tagging,
// D routing by source MSB and per-requester outstanding limits.
//
// Ports: clock/reset_n; in0_*/in1_* upstream A (in) and D (out) channels;
// out_* downstream A (out) and D (in) channels; busy = lock or any in-flight.
// A bits: {op,param,size,source,addr[14:0],mask[3:0],data[31:0]}.
// D bits: {op,size,source,error,data[31:0]}. Downstream source is 1 bit wider.
module tl_ul_arb2_sequencer #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int UP_SRC_W        = 6
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  in0_a_valid,
  output logic                  in0_a_ready,
  input  logic [UP_SRC_W+59:0]  in0_a_bits,
  output logic                  in0_d_valid,
  input  logic                  in0_d_ready,
  output logic [UP_SRC_W+38:0]  in0_d_bits,
  input  logic                  in1_a_valid,
  output logic                  in1_a_ready,
  input  logic [UP_SRC_W+59:0]  in1_a_bits,
  output logic                  in1_d_valid,
  input  logic                  in1_d_ready,
  output logic [UP_SRC_W+38:0]  in1_d_bits,
  output logic                  out_a_valid,
  input  logic                  out_a_ready,
  output logic [UP_SRC_W+60:0]  out_a_bits,
  input  logic                  out_d_valid,
  output logic                  out_d_ready,
  input  logic [UP_SRC_W+39:0]  out_d_bits,
  output logic                  busy
);

  localparam int AW   = UP_SRC_W + 60;
  localparam int DW   = UP_SRC_W + 39;
  localparam int SA   = 51;
  localparam int SD   = 33;
  localparam logic [3:0] MAX_O = 4'(MAX_OUTSTANDING);

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  beats_left_q, beats_left_d;
  logic        lock_owner_q, lock_owner_d;
  logic        last_grant_q, last_grant_d;
  logic        hold_q, hold_d;
  logic        hold_id_q, hold_id_d;
  logic [3:0]  outst0_q, outst1_q;
  logic [2:0]  d_left_q, d_left_d;

  function automatic logic [3:0] a_beats(
    input logic [2:0] op,
    input logic [2:0] sz
  );
    if (op[2:1] == 2'b00 && sz > 3'd2) begin
      if (sz == 3'd3) return 4'd2;
      if (sz == 3'd4) return 4'd4;
      return 4'd8;
    end
    return 4'd1;
  endfunction

  function automatic logic [3:0] d_beats(
    input logic [2:0] op,
    input logic [2:0] sz
  );
    if (op == 3'd1 && sz > 3'd2) begin
      if (sz == 3'd3) return 4'd2;
      if (sz == 3'd4) return 4'd4;
      return 4'd8;
    end
    return 4'd1;
  endfunction

  // ---------------- A arbitration ----------------
  logic          elig0, elig1;
  logic          sel_hold, sel_both, sel_0, sel_1;
  logic          gnt, gnt_any;
  logic [AW-1:0] sel_bits;
  logic [2:0]    a_op, a_sz;
  logic [3:0]    a_n;
  logic          a_fire, a_first, a_last;

  assign elig0 = in0_a_valid & (outst0_q < MAX_O);
  assign elig1 = in1_a_valid & (outst1_q < MAX_O);

  // A stalled requester keeps its grant so the offered beat cannot be
  // replaced by a newly eligible competitor while out_a_ready is low.
  assign sel_hold = hold_q & (hold_id_q ? elig1 : elig0);
  assign sel_both = ~sel_hold & elig0 & elig1;
  assign sel_0    = ~sel_hold & elig0 & ~elig1;
  assign sel_1    = ~sel_hold & ~elig0 & elig1;

  always_comb begin
    gnt     = 1'b0;
    gnt_any = 1'b0;
    if (state_q == BURST) begin
      gnt     = lock_owner_q;
      gnt_any = 1'b1;
    end else begin
      unique case (1'b1)
        sel_hold: begin
          gnt     = hold_id_q;
          gnt_any = 1'b1;
        end
        sel_both: begin
          gnt     = ~last_grant_q;
          gnt_any = 1'b1;
        end
        sel_0: begin
          gnt     = 1'b0;
          gnt_any = 1'b1;
        end
        sel_1: begin
          gnt     = 1'b1;
          gnt_any = 1'b1;
        end
        default: begin
          gnt     = 1'b0;
          gnt_any = 1'b0;
        end
      endcase
    end
  end

  assign sel_bits    = gnt ? in1_a_bits : in0_a_bits;
  assign out_a_valid = gnt_any & (gnt ? in1_a_valid : in0_a_valid);
  assign in0_a_ready = out_a_ready & gnt_any & ~gnt;
  assign in1_a_ready = out_a_ready & gnt_any & gnt;
  assign out_a_bits  = {sel_bits[AW-1:SA+UP_SRC_W], gnt,
                        sel_bits[SA+UP_SRC_W-1:0]};

  assign a_op    = sel_bits[AW-1:AW-3];
  assign a_sz    = sel_bits[AW-7:AW-9];
  assign a_n     = a_beats(a_op, a_sz);
  assign a_fire  = out_a_valid & out_a_ready;
  assign a_first = (state_q == IDLE);
  assign a_last  = a_first ? (a_n == 4'd1) : (beats_left_q == 3'd1);

  always_comb begin
    state_d      = state_q;
    beats_left_d = beats_left_q;
    lock_owner_d = lock_owner_q;
    last_grant_d = last_grant_q;
    hold_d       = out_a_valid & ~out_a_ready;
    hold_id_d    = gnt;
    unique case (state_q)
      IDLE: begin
        if (a_fire && a_n != 4'd1) begin
          state_d      = BURST;
          lock_owner_d = gnt;
          beats_left_d = 3'(a_n - 4'd1);
        end
      end
      BURST: begin
        if (a_fire) begin
          beats_left_d = beats_left_q - 3'd1;
          if (beats_left_q == 3'd1) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (a_fire && a_last) last_grant_d = gnt;
  end

  // ---------------- D routing ----------------
  logic       route;
  logic [2:0] d_op, d_sz;
  logic [3:0] d_n;
  logic       d_fire, d_last;
  logic [DW-1:0] d_strip;

  assign route       = out_d_bits[SD+UP_SRC_W];
  assign in0_d_valid = out_d_valid & ~route;
  assign in1_d_valid = out_d_valid & route;
  assign out_d_ready = route ? in1_d_ready : in0_d_ready;
  assign d_strip     = {out_d_bits[DW:SD+UP_SRC_W+1],
                        out_d_bits[SD+UP_SRC_W-1:0]};
  assign in0_d_bits  = d_strip;
  assign in1_d_bits  = d_strip;

  assign d_op   = out_d_bits[DW:DW-2];
  assign d_sz   = out_d_bits[DW-3:DW-5];
  assign d_n    = d_beats(d_op, d_sz);
  assign d_fire = out_d_valid & out_d_ready;
  // d_left_q == 0 marks the first beat of a response.
  assign d_last = (d_left_q == 3'd0) ? (d_n == 4'd1)
                                     : (d_left_q == 3'd1);

  always_comb begin
    d_left_d = d_left_q;
    if (d_fire) begin
      if (d_left_q == 3'd0) d_left_d = 3'(d_n - 4'd1);
      else                  d_left_d = d_left_q - 3'd1;
    end
  end

  // ---------------- outstanding counters ----------------
  logic inc0, inc1, dec0, dec1;

  assign inc0 = a_fire & a_first & ~gnt;
  assign inc1 = a_fire & a_first & gnt;
  assign dec0 = d_fire & d_last & ~route;
  assign dec1 = d_fire & d_last & route;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      beats_left_q <= 3'd0;
      lock_owner_q <= 1'b0;
      last_grant_q <= 1'b1;
      hold_q       <= 1'b0;
      hold_id_q    <= 1'b0;
      d_left_q     <= 3'd0;
      outst0_q     <= 4'd0;
      outst1_q     <= 4'd0;
    end else begin
      state_q      <= state_d;
      beats_left_q <= beats_left_d;
      lock_owner_q <= lock_owner_d;
      last_grant_q <= last_grant_d;
      hold_q       <= hold_d;
      hold_id_q    <= hold_id_d;
      d_left_q     <= d_left_d;
      unique case ({inc0, dec0})
        2'b10: if (outst0_q != 4'hf) outst0_q <= outst0_q + 4'd1;
        2'b01: if (outst0_q != 4'h0) outst0_q <= outst0_q - 4'd1;
        default: outst0_q <= outst0_q;
      endcase
      unique case ({inc1, dec1})
        2'b10: if (outst1_q != 4'hf) outst1_q <= outst1_q + 4'd1;
        2'b01: if (outst1_q != 4'h0) outst1_q <= outst1_q - 4'd1;
        default: outst1_q <= outst1_q;
      endcase
    end
  end

  assign busy = (state_q == BURST) | (|outst0_q) | (|outst1_q);

endmodule
